// File: rtl/shot_sequencer.sv
// Shot sequencer: arbitrates gun shots onto a single enemy-table read port.
// Each gun has a one-deep pending slot. Slots are granted round-robin. The
// enemy table is then scanned from slot 0 upward, and the first live enemy
// inside the hit box is reported. A scan that finds no such enemy reports a miss.
module shot_sequencer #(
  parameter int N_REQ   = 2,
  parameter int N_ENEMY = 8,
  parameter int HIT_R   = 16,
  localparam int IW = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1,
  localparam int RW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     shot,
  input  logic [N_REQ*10-1:0]  shoot_x,
  input  logic [N_REQ*9-1:0]   shoot_y,
  output logic [N_REQ-1:0]     drop,
  output logic [IW-1:0]        rd_idx,
  input  logic [9:0]           enemy_x,
  input  logic [8:0]           enemy_y,
  input  logic                 enemy_alive,
  output logic                 res_valid,
  output logic                 res_hit,
  output logic [IW-1:0]        res_idx,
  output logic [RW-1:0]        res_req,
  output logic                 busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_CMP  = 2'd2;
  localparam logic [1:0] S_RES  = 2'd3;

  logic [1:0]       state;
  logic [RW-1:0]    rr_ptr;
  logic [IW-1:0]    idx;
  logic [N_REQ-1:0] full;
  logic [9:0]       slot_x [N_REQ];
  logic [8:0]       slot_y [N_REQ];
  logic [9:0]       scan_x;
  logic [8:0]       scan_y;

  logic             grant_any;
  logic [RW-1:0]    grant_sel;
  logic [RW-1:0]    next_ptr;
  logic [N_REQ-1:0] granted;
  int               cand;

  logic [10:0]      dx, dy, adx, ady;
  logic             hit;

  // Round-robin pick of the first full slot, starting at rr_ptr, only while idle
  always_comb begin
    grant_any = 1'b0;
    grant_sel = '0;
    next_ptr  = '0;
    granted   = '0;
    cand      = 0;
    if (state == S_IDLE) begin
      for (int k = 0; k < N_REQ; k++) begin
        cand = (int'(rr_ptr) + k) % N_REQ;
        if (!grant_any && full[cand]) begin
          grant_any = 1'b1;
          grant_sel = RW'(cand);
          next_ptr  = RW'((cand + 1) % N_REQ);
        end
      end
      if (grant_any) begin
        granted[grant_sel] = 1'b1;
      end
    end
  end

  // Box test: 11-bit differences so that the full 10-bit coordinate range never wraps
  always_comb begin
    dx  = {1'b0, scan_x} - {1'b0, enemy_x};
    dy  = {2'b0, scan_y} - {2'b0, enemy_y};
    adx = dx[10] ? (~dx + 11'd1) : dx;
    ady = dy[10] ? (~dy + 11'd1) : dy;
    hit = (adx < 11'(HIT_R)) && (ady < 11'(HIT_R));
  end

  // Pending slots: a new shot overwrites a slot being granted, otherwise a full slot drops it
  always_ff @(posedge clk) begin
    if (reset) begin
      full <= '0;
      drop <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        drop[i] <= 1'b0;
        if (shot[i] && (!full[i] || granted[i])) begin
          slot_x[i] <= shoot_x[10*i +: 10];
          slot_y[i] <= shoot_y[9*i +: 9];
          full[i]   <= 1'b1;
        end else if (shot[i]) begin
          drop[i] <= 1'b1;
        end else if (granted[i]) begin
          full[i] <= 1'b0;
        end
      end
    end
  end

  // Scan FSM: grant a slot, then alternate read/compare over the table, then strobe the result
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      rr_ptr  <= '0;
      idx     <= '0;
      res_hit <= 1'b0;
      res_idx <= '0;
      res_req <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            scan_x  <= slot_x[grant_sel];
            scan_y  <= slot_y[grant_sel];
            res_req <= grant_sel;
            rr_ptr  <= next_ptr;
            idx     <= '0;
            state   <= S_RD;
          end
        end
        S_RD: state <= S_CMP;
        S_CMP: begin
          if (enemy_alive && hit) begin
            res_hit <= 1'b1;
            res_idx <= idx;
            state   <= S_RES;
          end else if (idx == IW'(N_ENEMY - 1)) begin
            res_hit <= 1'b0;
            res_idx <= '0;
            state   <= S_RES;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_RD;
          end
        end
        S_RES: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rd_idx    = idx;
  assign res_valid = (state == S_RES);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_shot_sequencer.sv
// Testbench for shot_sequencer: table-driven single-shot scans against a
// registered enemy-table model, followed by hand-written arbitration, drop
// and mid-scan reset sequences.
module tb_shot_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  shot;
  logic [19:0] shoot_x;
  logic [17:0] shoot_y;
  logic [1:0]  drop;
  logic [2:0]  rd_idx;
  logic [9:0]  enemy_x;
  logic [8:0]  enemy_y;
  logic        enemy_alive;
  logic        res_valid;
  logic        res_hit;
  logic [2:0]  res_idx;
  logic [0:0]  res_req;
  logic        busy;

  shot_sequencer #(.N_REQ(2), .N_ENEMY(8), .HIT_R(16)) dut (
    .clk(clk), .reset(reset), .shot(shot), .shoot_x(shoot_x), .shoot_y(shoot_y),
    .drop(drop), .rd_idx(rd_idx), .enemy_x(enemy_x), .enemy_y(enemy_y),
    .enemy_alive(enemy_alive), .res_valid(res_valid), .res_hit(res_hit),
    .res_idx(res_idx), .res_req(res_req), .busy(busy)
  );

  always #10 clk = ~clk;

  // Enemy table model with one-cycle read latency
  logic [9:0] ex_tab [8];
  logic [8:0] ey_tab [8];
  logic       al_tab [8];
  always @(posedge clk) begin
    enemy_x     <= ex_tab[rd_idx];
    enemy_y     <= ey_tab[rd_idx];
    enemy_alive <= al_tab[rd_idx];
  end

  // Cycle counter: cycle n runs from the n-th rising edge to the next
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct { int cyc; int req; int hit; int idx; } res_t;
  typedef struct { int cyc; int bits; } drop_t;
  res_t  resq[$];
  drop_t dropq[$];

  // Log every result strobe and drop pulse
  always @(negedge clk) begin
    if (!reset) begin
      if (res_valid) resq.push_back('{cyc, int'(res_req), int'(res_hit), int'(res_idx)});
      if (drop != 2'b00) dropq.push_back('{cyc, int'(drop)});
    end
  end

  typedef struct {
    int req; int ex; int ey; logic [7:0] alive;
    int sx; int sy; int hit; int idx; int lat;
  } vec_t;
  vec_t vecs[10];

  int compared = 0;
  int mismatched = 0;
  int t0;
  bit ok;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic applyStimulus(input logic [1:0] mask, input int x0, input int y0,
                               input int x1, input int y1, output int start);
    @(posedge clk); #2;
    shoot_x = {10'(x1), 10'(x0)};
    shoot_y = {9'(y1), 9'(y0)};
    shot    = mask;
    start   = cyc;
    @(posedge clk); #2;
    shot = 2'b00;
  endtask

  task automatic waitResults(input int n, input int budget, input string name, output bit done);
    int k = 0;
    while (resq.size() < n && k < budget) begin
      @(posedge clk); #2;
      k++;
    end
    done = (resq.size() >= n);
    compared++;
    if (!done) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d results, expected %0d", name, resq.size(), n);
    end
  endtask

  task automatic doReset();
    @(posedge clk); #2;
    reset = 1'b1;
    shot  = 2'b00;
    @(posedge clk); #2;
    @(posedge clk); #2;
    reset = 1'b0;
    resq.delete();
    dropq.delete();
  endtask

  task automatic setTable(input int ex, input int ey, input logic [7:0] alive);
    for (int e = 0; e < 8; e++) begin
      ex_tab[e] = 10'(ex);
      ey_tab[e] = 9'(ey);
      al_tab[e] = alive[e];
    end
  endtask

  initial begin
    reset   = 1'b1;
    shot    = 2'b00;
    shoot_x = '0;
    shoot_y = '0;
    setTable(0, 0, 8'h00);

    // {req, ex, ey, alive, sx, sy, hit, idx, latency}
    vecs[0] = '{0, 100, 100, 8'h08, 110,  95, 1, 3, 10};
    vecs[1] = '{0, 100, 100, 8'h01, 116, 100, 0, 0, 18};
    vecs[2] = '{1, 100, 100, 8'h01,  84, 100, 0, 0, 18};
    vecs[3] = '{0, 100, 100, 8'h01, 115, 115, 1, 0, 4};
    vecs[4] = '{1, 100, 100, 8'h01,  85,  85, 1, 0, 4};
    vecs[5] = '{0, 100, 100, 8'h01, 100, 116, 0, 0, 18};
    vecs[6] = '{1, 200, 200, 8'h24, 200, 200, 1, 2, 8};
    vecs[7] = '{0, 200, 200, 8'h00, 200, 200, 0, 0, 18};
    vecs[8] = '{1, 1023, 511, 8'h40, 1008, 496, 1, 6, 16};
    vecs[9] = '{0, 0, 0, 8'hff, 1023, 511, 0, 0, 18};

    @(posedge clk); #2;
    @(posedge clk); #2;
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset res_valid", int'(res_valid), 0);
    checkOutput("reset drop", int'(drop), 0);
    checkOutput("reset rd_idx", int'(rd_idx), 0);
    checkOutput("reset res_hit", int'(res_hit), 0);
    checkOutput("reset res_idx", int'(res_idx), 0);
    checkOutput("reset res_req", int'(res_req), 0);
    reset = 1'b0;

    for (int v = 0; v < 10; v++) begin
      setTable(vecs[v].ex, vecs[v].ey, vecs[v].alive);
      resq.delete();
      if (vecs[v].req == 0)
        applyStimulus(2'b01, vecs[v].sx, vecs[v].sy, 0, 0, t0);
      else
        applyStimulus(2'b10, 0, 0, vecs[v].sx, vecs[v].sy, t0);
      waitResults(1, 60, $sformatf("vec%0d result", v), ok);
      if (ok) begin
        checkOutput($sformatf("vec%0d res_hit", v), resq[0].hit, vecs[v].hit);
        checkOutput($sformatf("vec%0d res_idx", v), resq[0].idx, vecs[v].idx);
        checkOutput($sformatf("vec%0d res_req", v), resq[0].req, vecs[v].req);
        checkOutput($sformatf("vec%0d latency", v), resq[0].cyc - t0, vecs[v].lat);
      end
      @(posedge clk); #2;
      @(posedge clk); #2;
      checkOutput($sformatf("vec%0d idle busy", v), int'(busy), 0);
      checkOutput($sformatf("vec%0d result count", v), resq.size(), 1);
    end

    // Simultaneous shots: req0 first, then req1; repeat shows the pointer came back to 0
    doReset();
    setTable(100, 100, 8'h01);
    for (int rep = 0; rep < 2; rep++) begin
      resq.delete();
      applyStimulus(2'b11, 100, 100, 300, 300, t0);
      waitResults(2, 60, $sformatf("pair%0d results", rep), ok);
      if (ok) begin
        checkOutput($sformatf("pair%0d first req", rep), resq[0].req, 0);
        checkOutput($sformatf("pair%0d first hit", rep), resq[0].hit, 1);
        checkOutput($sformatf("pair%0d first lat", rep), resq[0].cyc - t0, 4);
        checkOutput($sformatf("pair%0d second req", rep), resq[1].req, 1);
        checkOutput($sformatf("pair%0d second hit", rep), resq[1].hit, 0);
        checkOutput($sformatf("pair%0d second lat", rep), resq[1].cyc - t0, 22);
      end
      waitUntil(cyc + 3);
    end

    // Continuous req0 shots must not starve req1
    doReset();
    setTable(100, 100, 8'h01);
    @(posedge clk); #2;
    shoot_x = {10'd100, 10'd100};
    shoot_y = {9'd100, 9'd100};
    shot[0] = 1'b1;
    t0 = cyc;
    waitUntil(t0 + 2);
    shot[1] = 1'b1;
    waitUntil(t0 + 3);
    shot[1] = 1'b0;
    waitResults(3, 40, "starve results", ok);
    if (ok) begin
      checkOutput("starve first req", resq[0].req, 0);
      checkOutput("starve second req", resq[1].req, 1);
      checkOutput("starve second lat", resq[1].cyc - t0, 8);
      checkOutput("starve third req", resq[2].req, 0);
    end
    shot = 2'b00;

    // Second shot into a full, ungranted slot is dropped
    doReset();
    setTable(100, 100, 8'h00);
    applyStimulus(2'b01, 100, 100, 0, 0, t0);
    waitUntil(t0 + 3);
    shoot_x[19:10] = 10'd50;
    shoot_y[17:9]  = 9'd50;
    shot[1] = 1'b1;
    waitUntil(t0 + 4);
    shot[1] = 1'b0;
    waitUntil(t0 + 5);
    shoot_x[19:10] = 10'd60;
    shot[1] = 1'b1;
    waitUntil(t0 + 6);
    shot[1] = 1'b0;
    waitResults(2, 60, "drop results", ok);
    if (ok) begin
      checkOutput("drop second req", resq[1].req, 1);
      checkOutput("drop second lat", resq[1].cyc - t0, 36);
    end
    checkOutput("drop count", dropq.size(), 1);
    if (dropq.size() > 0) begin
      checkOutput("drop bits", dropq[0].bits, 2);
      checkOutput("drop cycle", dropq[0].cyc - t0, 6);
    end
    waitUntil(cyc + 20);
    checkOutput("drop single result", resq.size(), 2);

    // Reset in the middle of a scan aborts it and discards pending shots
    doReset();
    setTable(100, 100, 8'h00);
    applyStimulus(2'b01, 100, 100, 0, 0, t0);
    waitUntil(t0 + 3);
    shot[1] = 1'b1;
    waitUntil(t0 + 4);
    shot[1] = 1'b0;
    waitUntil(t0 + 10);
    checkOutput("midscan rd_idx", int'(rd_idx), 4);
    checkOutput("midscan busy", int'(busy), 1);
    reset = 1'b1;
    waitUntil(t0 + 11);
    checkOutput("abort busy", int'(busy), 0);
    checkOutput("abort res_valid", int'(res_valid), 0);
    checkOutput("abort rd_idx", int'(rd_idx), 0);
    reset = 1'b0;
    waitUntil(cyc + 40);
    checkOutput("abort no results", resq.size(), 0);
    checkOutput("abort busy later", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
